reset_release_sequencer: RTL
============================

# reset_release_sequencer

- Downstream consumer of the power-on one-shot pulse.
- Waits for a START pulse, holds every reset domain in reset for a fixed time, then releases the domains one at a time in index order.
- Before each next release it inserts a gap and waits for that domain's READY (PLL lock, calibration done, etc.).
- Drives the per-domain active-high resets for the rest of the design and reports DONE or FAULT.

## Interface
- NUM_STAGES, 4: number of reset domains; must be 1..16.
- HOLD_CYCLES, 8: cycles all resets stay asserted after START; must be ≥1.
- GAP_CYCLES, 16: cycles between entering a stage and releasing its reset; must be ≥1.
- TIMEOUT_CYCLES, 1024: maximum wait for READY[idx]; used only when the timeout feature is compiled in; must be ≥1.
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  sequence trigger, sampled each edge; normally the one-shot OUT.
- READY  in  NUM_STAGES  per-domain ready; READY[i] is examined only while waiting on stage i.
- RST_OUT  out  NUM_STAGES  per-domain reset, active-high; bit i releases before bit i+1.
- STAGE  out  $clog2(NUM_STAGES)  index of the stage currently being sequenced; minimum width 1.
- DONE  out  1  high while all domains are released and ready.
- FAULT  out  1  high after a READY timeout; exists only with the timeout feature.

## Operation
- States:
  - IDLE, HOLD, GAP, WAIT_RDY, DONE.
  - FAULT is added with the timeout feature.
- Reset values: state IDLE; RST_OUT all ones; STAGE 0; DONE 0; FAULT 0; counter 0.
- IDLE: RST_OUT stays all ones. START=1 → HOLD, counter cleared.
- HOLD: counter increments. When counter reaches HOLD_CYCLES-1 → GAP, STAGE=0, counter cleared.
- GAP: counter increments. When counter reaches GAP_CYCLES-1:
  - clear RST_OUT[STAGE];
  - → WAIT_RDY, counter cleared.
- WAIT_RDY:
  - If READY[STAGE]=1 and STAGE=NUM_STAGES-1 → DONE.
  - Else if READY[STAGE]=1 → GAP, STAGE+1, counter cleared.
- DONE: DONE=1; STAGE holds NUM_STAGES-1. START=1 → HOLD and all RST_OUT reasserted (re-sequence).
- START in HOLD, GAP or WAIT_RDY is ignored; no restart mid-sequence.
- RST at any point, including mid-sequence, forces the reset values at the next edge. Already-released domains are immediately reasserted.
- READY bits of other stages are ignored. READY dropping after its stage has passed has no effect.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1). No counter wraps; every count is compared against its limit.

## Timing
- START sampled high at edge t0:
  - HOLD entered at t0;
  - GAP entered at t0+HOLD_CYCLES;
  - RST_OUT[0] falls at edge t0+HOLD_CYCLES+GAP_CYCLES.
- READY[i] first sampled high at edge t1: RST_OUT[i+1] falls at edge t1+GAP_CYCLES.
- READY high at the same edge a bit is released is not yet seen. It is first sampled one edge later, so there is a minimum of 1 cycle in WAIT_RDY.
- DONE rises at the edge that samples READY[NUM_STAGES-1]=1.
- If all READY are tied high, DONE rises at t0 + HOLD_CYCLES + NUM_STAGES·(GAP_CYCLES+1).
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- RSTSEQ_TIMEOUT_EN defined:
  - WAIT_RDY counts cycles. The counter reaching TIMEOUT_CYCLES-1 with READY[STAGE]=0 → FAULT.
  - FAULT: all RST_OUT reasserted, FAULT=1, DONE=0. STAGE keeps the failing index.
  - START=1 clears FAULT and → HOLD. If READY arrives on the same edge as the timeout, READY wins.
- RSTSEQ_TIMEOUT_EN undefined:
  - WAIT_RDY waits indefinitely.
  - The FAULT port, the FAULT state and TIMEOUT_CYCLES compare logic are absent.

## Structure
- Shared package rstseq_pkg holds:
  - the state enum (FAULT encoding always reserved);
  - a constant function for the counter width.
- One sub-module, rstseq_counter: clearable up-counter with a terminal-count compare output. It is instanced once and shared by HOLD, GAP and WAIT_RDY.

## Test plan
- Defaults, READY all 1, START pulse at edge 10 → RST_OUT 1111→1110 at 34, →1100 at 51, →1000 at 68, →0000 at 85; DONE=1 at 86.
- READY[1] held low 100 cycles then high → RST_OUT stays 1100 until READY[1] is sampled high; RST_OUT[2] falls 16 edges later.
- RST pulsed at edge 60 mid-sequence → at edge 61: RST_OUT=1111, STAGE=0, DONE=0, state IDLE; START pulses during the sequence are ignored.
- START pulse in DONE → all RST_OUT reasserted next edge; the full sequence repeats with identical timing.
- RSTSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=32, READY[2]=0 → FAULT=1 and RST_OUT=1111 32 cycles after RST_OUT[2] falls; a START pulse then restarts from HOLD.
- RSTSEQ_TIMEOUT_EN, READY[2] rises on the exact timeout edge → no FAULT; sequencing continues to stage 3.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset release sequencer.
// Holds the FSM state encoding (FAULT always reserved) and width helpers.
// Optional READY timeout is selected by RSTSEQ_TIMEOUT_EN in the users of this package.
package rstseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_GAP      = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Counter must hold the largest of the three limits without wrapping.
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

  // Stage index width, never narrower than one bit.
  function automatic int stage_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Bundle between the reset release sequencer and the domains it controls.
// master = sequencer (drives resets/status), slave = the rest of the design.
// The fault line exists only when RSTSEQ_TIMEOUT_EN is defined.
interface reset_release_sequencer_if
  import rstseq_pkg::*;
#(
  parameter int NUM_STAGES = 4
) ();
  localparam int SW = stage_width(NUM_STAGES);

  logic                  start;
  logic [NUM_STAGES-1:0] ready;
  logic [NUM_STAGES-1:0] rst_out;
  logic [SW-1:0]         stage;
  logic                  done;
`ifdef RSTSEQ_TIMEOUT_EN
  logic                  fault;
`endif

  modport master (
    input  start,
    input  ready,
    output rst_out,
    output stage,
`ifdef RSTSEQ_TIMEOUT_EN
    output fault,
`endif
    output done
  );

  modport slave (
    output start,
    output ready,
    input  rst_out,
    input  stage,
`ifdef RSTSEQ_TIMEOUT_EN
    input  fault,
`endif
    input  done
  );

endinterface

// File: rtl/rstseq_counter.sv
// Clearable up-counter with terminal-count compare against a run-time limit.
// Counts one per enabled edge; clear has priority; stops at the limit so it never wraps.
// tc is a pure compare of the registered count, so it adds no input-to-output path.
module rstseq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);
  logic [WIDTH-1:0] count;

  assign tc = (count == limit);

  // Count up while enabled, hold at the limit, clear on request or reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Holds all reset domains after START, then releases them in index order, gap + READY between.
// Latency: HOLD_CYCLES to first gap, GAP_CYCLES per release, >=1 cycle READY wait per stage.
// No backpressure; optional READY timeout to FAULT when RSTSEQ_TIMEOUT_EN is defined.
module reset_release_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                       clk,
  input logic                       rst,
  reset_release_sequencer_if.master bus
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int SW = stage_width(NUM_STAGES);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  state_t        state;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;
  logic [CW-1:0] cnt_limit;
  logic          rdy_cur;

  // Only the READY bit of the stage being waited on matters.
  assign rdy_cur = bus.ready[bus.stage];

  // One shared counter: limit and clear follow the state and the transition about to happen.
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = '0;
    case (state)
      ST_IDLE, ST_DONE: cnt_clr = bus.start;
      ST_HOLD: begin
        cnt_en    = 1'b1;
        cnt_limit = CW'(HOLD_CYCLES - 1);
        cnt_clr   = cnt_tc;
      end
      ST_GAP: begin
        cnt_en    = 1'b1;
        cnt_limit = CW'(GAP_CYCLES - 1);
        cnt_clr   = cnt_tc;
      end
      ST_WAIT_RDY: begin
`ifdef RSTSEQ_TIMEOUT_EN
        cnt_en    = 1'b1;
        cnt_limit = CW'(TIMEOUT_CYCLES - 1);
        cnt_clr   = rdy_cur || cnt_tc;
`else
        cnt_clr   = rdy_cur;
`endif
      end
`ifdef RSTSEQ_TIMEOUT_EN
      ST_FAULT: cnt_clr = bus.start;
`endif
      default: cnt_clr = 1'b1;
    endcase
  end

  rstseq_counter #(.WIDTH(CW)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  // Sequencing FSM with registered reset, stage and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.rst_out <= '1;
      bus.stage   <= '0;
      bus.done    <= 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
      bus.fault   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_tc) begin
            state     <= ST_GAP;
            bus.stage <= '0;
          end
        end
        ST_GAP: begin
          if (cnt_tc) begin
            bus.rst_out <= bus.rst_out & ~(NUM_STAGES'(1) << bus.stage);
            state       <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          // READY wins over a timeout landing on the same edge.
          if (rdy_cur) begin
            if (bus.stage == LAST_STAGE) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              state     <= ST_GAP;
              bus.stage <= bus.stage + SW'(1);
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else if (cnt_tc) begin
            state       <= ST_FAULT;
            bus.rst_out <= '1;
            bus.fault   <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          if (bus.start) begin
            state       <= ST_HOLD;
            bus.rst_out <= '1;
            bus.done    <= 1'b0;
          end
        end
`ifdef RSTSEQ_TIMEOUT_EN
        ST_FAULT: begin
          if (bus.start) begin
            state     <= ST_HOLD;
            bus.fault <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
